// File: rtl/interleaved_xbar_rr.sv
// Word-interleaved master-to-bank crossbar with one round-robin arbiter per slave port.
// Latency: request/grant path is combinational (0 cycles); the response returns exactly 1 cycle after the grant.
// Backpressure: s_gnt_i=0 withholds m_gnt_o and freezes that slave's pointer. Optional macro: XBAR_ADDR_COMPACT_EN.
module interleaved_xbar_rr #(
    parameter int NR_MASTER_PORTS  = 4,
    parameter int NR_SLAVE_PORTS   = 4,
    parameter int INTERLEAVE_WORDS = 1,
    parameter int DATA_WIDTH       = 32
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic [NR_MASTER_PORTS-1:0]                    m_req_i,
    output logic [NR_MASTER_PORTS-1:0]                    m_gnt_o,
    input  logic [NR_MASTER_PORTS-1:0][31:0]              m_add_i,
    input  logic [NR_MASTER_PORTS-1:0]                    m_wen_i,
    input  logic [NR_MASTER_PORTS-1:0][3:0]               m_be_i,
    input  logic [NR_MASTER_PORTS-1:0][DATA_WIDTH-1:0]    m_wdata_i,
    output logic [NR_MASTER_PORTS-1:0]                    m_r_valid_o,
    output logic [NR_MASTER_PORTS-1:0][DATA_WIDTH-1:0]    m_r_rdata_o,
    output logic [NR_MASTER_PORTS-1:0]                    m_r_opc_o,
    output logic [NR_SLAVE_PORTS-1:0]                     s_req_o,
    input  logic [NR_SLAVE_PORTS-1:0]                     s_gnt_i,
    output logic [NR_SLAVE_PORTS-1:0][31:0]               s_add_o,
    output logic [NR_SLAVE_PORTS-1:0]                     s_wen_o,
    output logic [NR_SLAVE_PORTS-1:0][3:0]                s_be_o,
    output logic [NR_SLAVE_PORTS-1:0][DATA_WIDTH-1:0]     s_wdata_o,
    input  logic [NR_SLAVE_PORTS-1:0][DATA_WIDTH-1:0]     s_r_rdata_i,
    input  logic [NR_SLAVE_PORTS-1:0]                     s_r_opc_i
);

    localparam int SEL_W = $clog2(NR_SLAVE_PORTS);
    localparam int OFF   = 2 + $clog2(INTERLEAVE_WORDS);
    localparam int PTR_W = (NR_MASTER_PORTS > 1) ? $clog2(NR_MASTER_PORTS) : 1;

    if (NR_MASTER_PORTS < 1) begin : g_bad_masters
        $error("NR_MASTER_PORTS must be at least 1");
    end
    if (NR_SLAVE_PORTS < 2 || (NR_SLAVE_PORTS & (NR_SLAVE_PORTS - 1)) != 0) begin : g_bad_slaves
        $error("NR_SLAVE_PORTS must be a power of two >= 2");
    end
    if (INTERLEAVE_WORDS < 1 || (INTERLEAVE_WORDS & (INTERLEAVE_WORDS - 1)) != 0) begin : g_bad_interleave
        $error("INTERLEAVE_WORDS must be a power of two");
    end

    logic [SEL_W-1:0] tgt     [NR_MASTER_PORTS];
    logic [PTR_W-1:0] ptr_q   [NR_SLAVE_PORTS];
    logic [PTR_W-1:0] win     [NR_SLAVE_PORTS];
    logic [NR_SLAVE_PORTS-1:0]  any_req;
    logic [NR_MASTER_PORTS-1:0] r_vld_q;
    logic [SEL_W-1:0] r_sel_q [NR_MASTER_PORTS];

    // Bank address seen by the slave: either the full byte address or one with the bank-select field squeezed out.
    function automatic logic [31:0] map_add(input logic [31:0] a);
`ifdef XBAR_ADDR_COMPACT_EN
        logic [31:0] lo_mask;
        lo_mask = (32'd1 << OFF) - 32'd1;
        return ((a >> (OFF + SEL_W)) << OFF) | (a & lo_mask);
`else
        return a;
`endif
    endfunction

    always_comb begin
        for (int m = 0; m < NR_MASTER_PORTS; m++) begin
            tgt[m] = m_add_i[m][OFF +: SEL_W];
        end
    end

    // Search upward from the pointer with wrap-around; first hit wins.
    always_comb begin
        for (int s = 0; s < NR_SLAVE_PORTS; s++) begin
            any_req[s] = 1'b0;
            win[s]     = '0;
            for (int k = 0; k < NR_MASTER_PORTS; k++) begin
                int j;
                j = int'(ptr_q[s]) + k;
                if (j >= NR_MASTER_PORTS) j = j - NR_MASTER_PORTS;
                if (!any_req[s] && m_req_i[j] && tgt[j] == SEL_W'(s)) begin
                    any_req[s] = 1'b1;
                    win[s]     = PTR_W'(j);
                end
            end
        end
    end

    always_comb begin
        m_gnt_o = '0;
        for (int s = 0; s < NR_SLAVE_PORTS; s++) begin
            s_req_o[s]   = any_req[s] & ~rst_i;
            s_add_o[s]   = '0;
            s_wen_o[s]   = 1'b0;
            s_be_o[s]    = '0;
            s_wdata_o[s] = '0;
            if (any_req[s] && !rst_i) begin
                s_add_o[s]   = map_add(m_add_i[win[s]]);
                s_wen_o[s]   = m_wen_i[win[s]];
                s_be_o[s]    = m_be_i[win[s]];
                s_wdata_o[s] = m_wdata_i[win[s]];
                if (s_gnt_i[s]) m_gnt_o[win[s]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < NR_SLAVE_PORTS; s++) ptr_q[s] <= '0;
            r_vld_q <= '0;
            for (int m = 0; m < NR_MASTER_PORTS; m++) r_sel_q[m] <= '0;
        end else begin
            for (int s = 0; s < NR_SLAVE_PORTS; s++) begin
                if (any_req[s] && s_gnt_i[s]) begin
                    ptr_q[s] <= (int'(win[s]) == NR_MASTER_PORTS - 1) ? '0 : win[s] + 1'b1;
                end
            end
            r_vld_q <= m_gnt_o;
            for (int m = 0; m < NR_MASTER_PORTS; m++) r_sel_q[m] <= tgt[m];
        end
    end

    // Responses are gated by reset so a grant followed by reset never surfaces.
    always_comb begin
        for (int m = 0; m < NR_MASTER_PORTS; m++) begin
            m_r_valid_o[m] = r_vld_q[m] & ~rst_i;
            m_r_rdata_o[m] = m_r_valid_o[m] ? s_r_rdata_i[r_sel_q[m]] : '0;
            m_r_opc_o[m]   = m_r_valid_o[m] ? s_r_opc_i[r_sel_q[m]] : 1'b0;
        end
    end

endmodule
